led_pwm_fader: RTL and testbench
================================

Name: led_pwm_fader

Overview:
- Multi-channel LED driver. Successor to the fixed-rate RGB blinker.
- Per-channel PWM brightness, selectable off/static/blink/breathe mode, and a programmable step prescaler in place of hard-wired counter bits.
- Sits between board LED pins and the control/config logic. Default configuration drives the RGB LED (3 channels).

Parameters:
- p_channels, 3: number of LED channels.
- p_pwm_bits, 8: PWM counter and duty width. Frame length = 2^p_pwm_bits clocks.
- p_step_bits, 16: prescaler width for envelope/blink steps.

Ports:
- i_clk, in, 1: system clock.
- i_rst, in, 1: reset.
- i_mode, in, 2: 0 = off, 1 = static, 2 = blink, 3 = breathe.
- i_level, in, p_channels*p_pwm_bits: per-channel maximum duty. Channel c occupies bits [c*p_pwm_bits +: p_pwm_bits].
- i_step_div, in, p_step_bits: step period minus 1, in clocks.
- o_step, out, 1: one-cycle pulse per step tick.
- o_led, out, p_channels: PWM outputs, active-high, registered.

Behaviour:
- Interface: one clock, i_clk; i_rst is synchronous and active-high.
- Reset: all state is cleared to 0.
  - Cleared: r_pwm_cnt, r_pre, r_step_cnt (p_channels bits), r_env[c], r_duty[c], r_mode (= off), o_led, o_step.
  - r_dir[c] resets to up.
  - Asserting reset mid-frame clears everything on the next edge. o_led is low the cycle after reset is sampled.
- PWM counter:
  - r_pwm_cnt increments every clock and wraps from 2^W-1 to 0.
  - The "frame edge" is the clock edge where r_pwm_cnt == 2^W-1.
- Prescaler and step tick:
  - tick = (r_pre >= i_step_div).
  - On tick: r_pre <= 0, o_step <= 1 (one cycle), r_step_cnt <= r_step_cnt + 1 (wraps).
  - Otherwise r_pre increments.
  - i_step_div = 0 gives a tick every cycle. Lowering i_step_div below r_pre ticks on the next cycle.
- Breathe envelope, updated per channel on tick only when r_mode == 3:
  - Up, and r_env+1 >= level: r_env <= level, r_dir <= down.
  - Up, otherwise: r_env <= r_env + 1.
  - Down, and r_env <= 1: r_env <= 0, r_dir <= up.
  - Down, otherwise: r_env <= r_env - 1.
  - level = 0 holds r_env at 0. Lowering level while ramping up clamps r_env on the next tick.
- Frame edge: r_duty[c] and r_mode latch.
  - r_mode <= i_mode.
  - Duty source by i_mode: off → 0; static → level[c]; blink → r_step_cnt[c] ? level[c] : 0; breathe → r_env[c].
  - If i_mode != r_mode at that edge (mode change):
    - r_env <= 0, r_dir <= up, r_step_cnt <= 0; this overrides a coincident tick.
    - Latched duty = level[c] if the new mode is static, otherwise 0.
  - Level changes between frame edges never affect the current frame (glitch-free).
- Output:
  - o_led[c] <= (r_pwm_cnt < r_duty[c]), registered, so 1-cycle latency.
  - Duty d gives exactly d high cycles per 2^W-cycle frame. Duty 2^W-1 is the maximum (one low cycle per frame).
- Blink: channel c toggles at half the rate of channel c-1 (period 2^(c+1) ticks), matching the legacy per-bit blink.

Decomposition:
- Package led_pwm_pkg holds:
  - mode localparams MODE_OFF/STATIC/BLINK/BREATHE;
  - the direction encoding;
  - a function extracting level[c] from the packed bus.
- Sub-module led_pwm_channel holds one channel's envelope, duty latch and comparator. It is instantiated p_channels times in a generate loop. The top owns r_pwm_cnt, the prescaler, r_step_cnt and r_mode.

Test Plan (p_pwm_bits = 4, p_channels = 3, frame = 16 clocks):
1. Reset, then static level 8: hold i_rst 5 cycles with i_mode = 1, level0 = 8 → o_led = 0 during reset and for the first frame (duty 0 latched). From the second frame, o_led[0] is high 8 of 16 cycles, starting 1 cycle after r_pwm_cnt = 0.
2. Static boundaries and mid-frame change: level 0 → o_led never high; level 15 → high 15/16. Changing level 4 → 12 mid-frame → current frame shows 4 high cycles, next frame 12.
3. Blink: i_step_div = 31, level = 15 on all channels → o_step every 32 cycles. ch0 alternates 2 frames on / 2 off, ch1 4/4, ch2 8/8.
4. Breathe: i_step_div = 15, level0 = 3 → per-frame duty 0,0,1,2,3,2,1,0,1,2…; level0 = 0 → always dark.
5. Mode change breathe → static mid-frame (level 5): old duty until the frame edge, then 5 high cycles. Returning to breathe restarts the envelope at 0/up and the first new frame is dark.
6. Prescaler: i_step_div = 7 → o_step every 8 cycles, 1 cycle wide. Changing i_step_div to 2 while r_pre = 5 → o_step on the next cycle, then every 3 cycles.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Purpose: shared mode/direction encodings and level-bus helper for the LED PWM fader.
// Latency: n/a (constants and a pure function only).
// Backpressure: none; nothing in here carries flow control.
package led_pwm_pkg;

  // Operating modes, as presented on i_mode and held in r_mode.
  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STATIC  = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  // Breathe envelope direction.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest level bus / duty the helper below can slice. Callers zero-extend
  // their bus to LEVEL_BUS_MAX bits and truncate the result to their duty width.
  localparam int LEVEL_BUS_MAX = 256;
  localparam int PWM_BITS_MAX  = 16;

  // Extract channel idx's level from a packed bus of bits-wide fields.
  function automatic logic [PWM_BITS_MAX-1:0] level_of(
    input logic [LEVEL_BUS_MAX-1:0] bus,
    input int unsigned              idx,
    input int unsigned              bits
  );
    logic [LEVEL_BUS_MAX-1:0] shifted;
    logic [LEVEL_BUS_MAX-1:0] mask;
    shifted = bus >> (idx * bits);
    mask    = (LEVEL_BUS_MAX'(1) << bits) - LEVEL_BUS_MAX'(1);
    return PWM_BITS_MAX'(shifted & mask);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// Purpose: one LED channel -- breathe envelope, per-frame duty latch, PWM comparator.
// Latency: o_led is registered, 1 cycle after the PWM count it is compared against.
// Backpressure: none; free-running, inputs are sampled every clock.
//
// Ports: i_clk/i_rst (sync, active-high); pwm_cnt, frame_edge, tick, mode_chg,
// cur_mode (latched) and new_mode (incoming) from the top; blink_bit is this
// channel's bit of the shared step counter; level is this channel's max duty.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int p_pwm_bits = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [p_pwm_bits-1:0] pwm_cnt,
  input  logic                  frame_edge,
  input  logic                  tick,
  input  logic                  mode_chg,
  input  logic [1:0]            cur_mode,
  input  logic [1:0]            new_mode,
  input  logic                  blink_bit,
  input  logic [p_pwm_bits-1:0] level,
  output logic                  led
);

  logic [p_pwm_bits-1:0] r_env;
  logic                  r_dir;
  logic [p_pwm_bits-1:0] r_duty;

  logic [p_pwm_bits-1:0] env_nxt;
  logic                  dir_nxt;
  logic [p_pwm_bits-1:0] duty_src;
  logic [p_pwm_bits:0]   env_inc;

  // One bit wider so r_env+1 cannot wrap when level is at full scale.
  assign env_inc = {1'b0, r_env} + (p_pwm_bits+1)'(1);

  // Envelope: a mode change restarts it; otherwise it only moves on a step
  // tick while the latched mode is breathe.
  always_comb begin
    env_nxt = r_env;
    dir_nxt = r_dir;
    if (mode_chg) begin
      env_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (tick && (cur_mode == MODE_BREATHE)) begin
      if (r_dir == DIR_UP) begin
        // Also clamps r_env down to level if level dropped mid-ramp.
        if (env_inc >= {1'b0, level}) begin
          env_nxt = level;
          dir_nxt = DIR_DOWN;
        end else begin
          env_nxt = env_inc[p_pwm_bits-1:0];
        end
      end else begin
        if (r_env <= p_pwm_bits'(1)) begin
          env_nxt = '0;
          dir_nxt = DIR_UP;
        end else begin
          env_nxt = r_env - p_pwm_bits'(1);
        end
      end
    end
  end

  // Duty to latch at the frame edge. On a mode change only static shows
  // its level straight away; the other modes start dark.
  always_comb begin
    duty_src = '0;
    if (mode_chg) begin
      duty_src = (new_mode == MODE_STATIC) ? level : '0;
    end else begin
      case (new_mode)
        MODE_STATIC:  duty_src = level;
        MODE_BLINK:   duty_src = blink_bit ? level : '0;
        MODE_BREATHE: duty_src = r_env;
        default:      duty_src = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_env  <= '0;
      r_dir  <= DIR_UP;
      r_duty <= '0;
      led    <= 1'b0;
    end else begin
      r_env <= env_nxt;
      r_dir <= dir_nxt;
      // Duty only moves at the frame edge so a frame is never cut short.
      if (frame_edge) begin
        r_duty <= duty_src;
      end
      led <= (pwm_cnt < r_duty);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// Purpose: multi-channel LED PWM driver with off/static/blink/breathe modes and step prescaler.
// Latency: o_led registered, 1 cycle behind r_pwm_cnt; duty/mode changes take effect at the next frame edge.
// Backpressure: none; free-running, inputs sampled every clock.
//
// Ports: i_clk, i_rst (sync, active-high); i_mode (0 off/1 static/2 blink/3 breathe);
// i_level packed per-channel max duty; i_step_div = step period - 1;
// o_step one-cycle pulse per step tick; o_led per-channel PWM output.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int p_channels  = 3,
  parameter int p_pwm_bits  = 8,
  parameter int p_step_bits = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [1:0]                       i_mode,
  input  logic [p_channels*p_pwm_bits-1:0] i_level,
  input  logic [p_step_bits-1:0]           i_step_div,
  output logic                             o_step,
  output logic [p_channels-1:0]            o_led
);

  logic [p_pwm_bits-1:0]    r_pwm_cnt;
  logic [p_step_bits-1:0]   r_pre;
  logic [p_channels-1:0]    r_step_cnt;
  logic [1:0]               r_mode;

  logic                     tick;
  logic                     frame_edge;
  logic                     mode_chg;
  logic [LEVEL_BUS_MAX-1:0] level_bus;

  // >= rather than == so lowering i_step_div below r_pre ticks at once
  // instead of waiting for the prescaler to wrap.
  assign tick       = (r_pre >= i_step_div);
  assign frame_edge = (r_pwm_cnt == {p_pwm_bits{1'b1}});
  assign mode_chg   = frame_edge && (i_mode != r_mode);
  assign level_bus  = LEVEL_BUS_MAX'(i_level);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_cnt  <= '0;
      r_pre      <= '0;
      r_step_cnt <= '0;
      r_mode     <= MODE_OFF;
      o_step     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + p_pwm_bits'(1);
      if (tick) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + p_step_bits'(1);
      end
      o_step <= tick;
      // A mode change restarts blink phase even if a tick lands on the same edge.
      if (mode_chg) begin
        r_step_cnt <= '0;
      end else if (tick) begin
        r_step_cnt <= r_step_cnt + p_channels'(1);
      end
      if (frame_edge) begin
        r_mode <= i_mode;
      end
    end
  end

  // Channel c blinks from bit c of the step counter, so each channel runs
  // at half the rate of the one below it.
  for (genvar c = 0; c < p_channels; c++) begin : g_ch
    logic [p_pwm_bits-1:0] ch_level;
    assign ch_level = p_pwm_bits'(level_of(level_bus, c, p_pwm_bits));

    led_pwm_channel #(
      .p_pwm_bits(p_pwm_bits)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .pwm_cnt    (r_pwm_cnt),
      .frame_edge (frame_edge),
      .tick       (tick),
      .mode_chg   (mode_chg),
      .cur_mode   (r_mode),
      .new_mode   (i_mode),
      .blink_bit  (r_step_cnt[c]),
      .level      (ch_level),
      .led        (o_led[c])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
module tb_led_pwm_fader;

  localparam int NCH   = 3;
  localparam int W     = 4;
  localparam int SB    = 16;
  localparam int FRAME = 16;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [1:0]        i_mode;
  logic [NCH*W-1:0]  i_level;
  logic [SB-1:0]     i_step_div;
  logic              o_step;
  logic [NCH-1:0]    o_led;

  led_pwm_fader #(.p_channels(NCH), .p_pwm_bits(W), .p_step_bits(SB)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_mode     (i_mode),
    .i_level    (i_level),
    .i_step_div (i_step_div),
    .o_step     (o_step),
    .o_led      (o_led)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model (integer arithmetic) ----------------
  int          m_cnt = 0, m_pre = 0, m_step = 0, m_mode = 0;
  int          m_env[NCH];
  bit          m_up[NCH];
  int          m_duty[NCH];
  logic [NCH-1:0] m_led = '0;
  logic        m_step_o = 1'b0;

  always @(posedge i_clk) begin
    bit tick, fe, chg;
    int lvl;
    if (i_rst) begin
      m_cnt = 0; m_pre = 0; m_step = 0; m_mode = 0;
      m_led = '0; m_step_o = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_env[c] = 0; m_up[c] = 1'b1; m_duty[c] = 0;
      end
    end else begin
      tick = (m_pre >= int'(i_step_div));
      fe   = (m_cnt == FRAME - 1);
      chg  = fe && (int'(i_mode) != m_mode);
      for (int c = 0; c < NCH; c++) m_led[c] = (m_cnt < m_duty[c]);
      for (int c = 0; c < NCH; c++) begin
        lvl = int'(i_level[c*W +: W]);
        if (fe) begin
          if (chg)                 m_duty[c] = (i_mode == 2'd1) ? lvl : 0;
          else if (i_mode == 2'd1) m_duty[c] = lvl;
          else if (i_mode == 2'd2) m_duty[c] = (((m_step >> c) & 1) != 0) ? lvl : 0;
          else if (i_mode == 2'd3) m_duty[c] = m_env[c];
          else                     m_duty[c] = 0;
        end
        if (chg) begin
          m_env[c] = 0; m_up[c] = 1'b1;
        end else if (tick && m_mode == 3) begin
          if (m_up[c]) begin
            if (m_env[c] + 1 >= lvl) begin m_env[c] = lvl; m_up[c] = 1'b0; end
            else m_env[c] = m_env[c] + 1;
          end else begin
            if (m_env[c] <= 1) begin m_env[c] = 0; m_up[c] = 1'b1; end
            else m_env[c] = m_env[c] - 1;
          end
        end
      end
      m_step_o = tick;
      if (chg)       m_step = 0;
      else if (tick) m_step = (m_step + 1) % (1 << NCH);
      m_pre = tick ? 0 : m_pre + 1;
      m_cnt = (m_cnt + 1) % FRAME;
      if (fe) m_mode = int'(i_mode);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    n_vec++;
    if (o_led !== m_led || o_step !== m_step_o) begin
      n_err++;
      $display("FAIL model t=%0t: o_led=%b o_step=%b, expected o_led=%b o_step=%b",
               $time, o_led, o_step, m_led, m_step_o);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      check("reset_led", int'(o_led), 0);
    end
    i_rst = 1'b0;
  endtask

  // Sample one full frame of o_led (o_led lags the counter by one cycle, so
  // the window runs counter 1..15,0). Optionally changes mode/level0 mid-frame.
  task automatic measure(input int chg_at, input logic [1:0] nm, input logic [W-1:0] nl,
                         output logic [FRAME-1:0] p0, output logic [FRAME-1:0] p1,
                         output logic [FRAME-1:0] p2);
    int guard;
    guard = 0;
    p0 = '0; p1 = '0; p2 = '0;
    @(negedge i_clk);
    while (m_cnt != 1 && guard < 4*FRAME) begin
      @(negedge i_clk);
      guard++;
    end
    if (m_cnt != 1) check("measure_sync_timeout", m_cnt, 1);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge i_clk);
      p0[i] = o_led[0]; p1[i] = o_led[1]; p2[i] = o_led[2];
      if (i == chg_at) begin
        i_mode = nm;
        i_level[W-1:0] = nl;
      end
    end
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic [W-1:0]     lvl;
    logic [FRAME-1:0] exp_pat;
  } vec_t;

  vec_t tbl[7];
  int   exp_br[10] = '{0, 0, 1, 2, 3, 2, 1, 0, 1, 2};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [FRAME-1:0] p0, p1, p2;
    int pat, guard, on, steps;

    tbl[0] = '{mode: 2'd1, lvl: 4'd0,  exp_pat: 16'h0000};
    tbl[1] = '{mode: 2'd1, lvl: 4'd15, exp_pat: 16'h7FFF};
    tbl[2] = '{mode: 2'd1, lvl: 4'd8,  exp_pat: 16'h00FF};
    tbl[3] = '{mode: 2'd1, lvl: 4'd1,  exp_pat: 16'h0001};
    tbl[4] = '{mode: 2'd0, lvl: 4'd9,  exp_pat: 16'h0000};
    tbl[5] = '{mode: 2'd3, lvl: 4'd0,  exp_pat: 16'h0000};
    tbl[6] = '{mode: 2'd1, lvl: 4'd4,  exp_pat: 16'h000F};

    // 1. reset, static level 8 on ch0
    i_rst = 1'b1; i_mode = 2'd1; i_level = '0; i_level[3:0] = 4'd8; i_step_div = 16'd15;
    do_reset(5);
    measure(-1, 2'd0, 4'd0, p0, p1, p2);
    check("t1_first_frame_dark", int'(p0), 0);
    measure(-1, 2'd0, 4'd0, p0, p1, p2);
    check("t1_second_frame_ch0", int'(p0), 16'h00FF);
    check("t1_second_frame_ch1", int'(p1), 0);

    // 2. static/off/breathe boundaries from the table
    for (int v = 0; v < 7; v++) begin
      i_mode  = tbl[v].mode;
      i_level = {NCH{tbl[v].lvl}};
      measure(-1, 2'd0, 4'd0, p0, p1, p2);
      measure(-1, 2'd0, 4'd0, p0, p1, p2);
      measure(-1, 2'd0, 4'd0, p0, p1, p2);
      check($sformatf("tbl%0d_ch0", v), int'(p0), int'(tbl[v].exp_pat));
      check($sformatf("tbl%0d_ch1", v), int'(p1), int'(tbl[v].exp_pat));
      check($sformatf("tbl%0d_ch2", v), int'(p2), int'(tbl[v].exp_pat));
    end

    // 2b. level 4 -> 12 mid-frame on ch0: current frame unaffected
    measure(6, 2'd1, 4'd12, p0, p1, p2);
    check("midlvl_cur_frame", int'(p0), 16'h000F);
    check("midlvl_other_ch", int'(p1), 16'h000F);
    measure(-1, 2'd1, 4'd12, p0, p1, p2);
    check("midlvl_next_frame", int'(p0), 16'h0FFF);

    // mid-frame reset: o_led low the cycle after reset is sampled
    guard = 0;
    @(negedge i_clk);
    while (m_cnt != 3 && guard < 40) begin @(negedge i_clk); guard++; end
    check("pre_reset_led0", int'(o_led[0]), 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midframe_reset_led", int'(o_led), 0);
    check("midframe_reset_step", int'(o_step), 0);
    i_rst = 1'b0;

    // 3. blink, step every 32 cycles, full level on all channels
    i_mode = 2'd2; i_level = {NCH{4'd15}}; i_step_div = 16'd31;
    do_reset(3);
    for (int k = 1; k <= 20; k++) begin
      measure(-1, 2'd2, 4'd15, p0, p1, p2);
      for (int c = 0; c < NCH; c++) begin
        on  = (k >= 3) ? ((((k - 2) / 2) >> c) & 1) : 0;
        pat = (c == 0) ? int'(p0) : (c == 1) ? int'(p1) : int'(p2);
        check($sformatf("blink_f%0d_ch%0d", k, c), pat, on ? 16'h7FFF : 0);
      end
    end
    steps = 0;
    for (int k = 0; k < 64; k++) begin @(negedge i_clk); steps += int'(o_step); end
    check("blink_step_count_64", steps, 2);

    // 4. breathe, step every frame, level0 = 3
    i_mode = 2'd3; i_level = '0; i_level[3:0] = 4'd3; i_step_div = 16'd15;
    do_reset(3);
    measure(-1, 2'd3, 4'd3, p0, p1, p2);
    for (int k = 0; k < 10; k++) begin
      measure(-1, 2'd3, 4'd3, p0, p1, p2);
      check($sformatf("breathe_f%0d", k), $countones(p0), exp_br[k]);
    end
    i_level[3:0] = 4'd0;
    for (int k = 0; k < 4; k++) measure(-1, 2'd3, 4'd0, p0, p1, p2);
    for (int k = 0; k < 3; k++) begin
      measure(-1, 2'd3, 4'd0, p0, p1, p2);
      check($sformatf("breathe_lvl0_f%0d", k), int'(p0), 0);
    end

    // 5. breathe -> static -> breathe, level 5
    i_level[3:0] = 4'd5;
    for (int k = 0; k < 6; k++) measure(-1, 2'd3, 4'd5, p0, p1, p2);
    measure(6, 2'd1, 4'd5, p0, p1, p2);
    measure(-1, 2'd1, 4'd5, p0, p1, p2);
    check("to_static_first", int'(p0), 16'h001F);
    measure(6, 2'd3, 4'd5, p0, p1, p2);
    check("to_breathe_old_frame", int'(p0), 16'h001F);
    measure(-1, 2'd3, 4'd5, p0, p1, p2);
    check("to_breathe_f0", int'(p0), 0);
    measure(-1, 2'd3, 4'd5, p0, p1, p2);
    check("to_breathe_f1", int'(p0), 0);
    measure(-1, 2'd3, 4'd5, p0, p1, p2);
    check("to_breathe_f2", int'(p0), 16'h0001);

    // 6. prescaler: period 8, then shrink to 3 while r_pre = 5
    i_mode = 2'd0; i_step_div = 16'd7;
    do_reset(2);
    pat = 0;
    for (int k = 0; k < 24; k++) begin @(negedge i_clk); pat |= int'(o_step) << k; end
    check("presc_div7", pat, 32'h0080_8080);
    guard = 0;
    @(negedge i_clk);
    while (m_pre != 5 && guard < 20) begin @(negedge i_clk); guard++; end
    check("presc_sync_pre5", m_pre, 5);
    i_step_div = 16'd2;
    pat = 0;
    for (int k = 0; k < 10; k++) begin @(negedge i_clk); pat |= int'(o_step) << k; end
    check("presc_div2", pat, 32'h0000_0249);

    // 7. randomized phase, checked cycle by cycle against the model
    for (int k = 0; k < 2500; k++) begin
      @(negedge i_clk);
      if ($urandom_range(0, 59) == 0) begin
        i_rst = 1'b1;
      end else begin
        i_rst = 1'b0;
        if ($urandom_range(0, 9) == 0) i_mode = 2'($urandom);
        if ($urandom_range(0, 7) == 0) i_level = 12'($urandom);
        if ($urandom_range(0, 29) == 0)
          i_step_div = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 40));
      end
    end
    i_rst = 1'b0;
    @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
